// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong game core.
//   game_state_e : top-level game phase, encoded as it appears on game_state.
//   SEL_*        : readout-select codes for the data_out mux.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_PLAY  = 2'd2,
    ST_OVER  = 2'd3
  } game_state_e;

  localparam logic [2:0] SEL_BALL_X   = 3'd0;
  localparam logic [2:0] SEL_BALL_Y   = 3'd1;
  localparam logic [2:0] SEL_PADDLE_L = 3'd2;
  localparam logic [2:0] SEL_PADDLE_R = 3'd3;
  localparam logic [2:0] SEL_SCORE_L  = 3'd4;
  localparam logic [2:0] SEL_SCORE_R  = 3'd5;
  localparam logic [2:0] SEL_STATE    = 3'd6;
  localparam logic [2:0] SEL_ZERO     = 3'd7;

endpackage

// File: rtl/pong_paddle.sv
// Single paddle: a saturating up/down position register advanced on en.
//   clk, rst_n : clock and synchronous active-low reset
//   en         : advance strobe (game tick while the paddle is live)
//   up, dn     : move commands; both or neither hold the position
//   pos        : paddle centre, kept within [PADDLE_HALF, SCREEN_H-1-PADDLE_HALF]
module pong_paddle #(
  parameter int COORD_W     = 8,
  parameter int SCREEN_H    = 48,
  parameter int PADDLE_HALF = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               up,
  input  logic               dn,
  output logic [COORD_W-1:0] pos
);

  localparam logic [COORD_W-1:0] POS_RESET = COORD_W'(SCREEN_H / 2);
  localparam logic [COORD_W-1:0] POS_MIN   = COORD_W'(PADDLE_HALF);
  localparam logic [COORD_W-1:0] POS_MAX   = COORD_W'(SCREEN_H - 1 - PADDLE_HALF);
  localparam logic [COORD_W-1:0] POS_ONE   = COORD_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; reset is synchronous, checked first in the block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos <= POS_RESET;
    end else if (en && up && !dn && (pos > POS_MIN)) begin
      pos <= pos - POS_ONE;
    end else if (en && dn && !up && (pos < POS_MAX)) begin
      pos <= pos + POS_ONE;
    end
  end

endmodule

// File: rtl/pong_engine.sv
// Pong game core: two paddles, a bouncing ball, scores, a serve/play/over
// state machine and a registered debug readout. Everything advances on the
// one-cycle tick strobe in the clk domain.
//   clk, rst_n          : clock, synchronous active-low reset
//   tick                : game-advance strobe
//   start               : begin a new game (honoured only in IDLE/OVER)
//   up_l/dn_l/up_r/dn_r : paddle commands
//   sel                 : readout select for data_out
//   data_out            : registered readout of the selected value
//   ball_x, ball_y      : ball position
//   paddle_l, paddle_r  : paddle centres
//   score_l, score_r    : scores
//   game_state          : IDLE/SERVE/PLAY/OVER
//   point_pulse         : one-clk strobe after a point is scored
module pong_engine
  import pong_pkg::*;
#(
  parameter int SCREEN_W    = 64,
  parameter int SCREEN_H    = 48,
  parameter int COORD_W     = 8,
  parameter int PADDLE_HALF = 3,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_DELAY = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic               start,
  input  logic               up_l,
  input  logic               dn_l,
  input  logic               up_r,
  input  logic               dn_r,
  input  logic [2:0]         sel,
  output logic [7:0]         data_out,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic [COORD_W-1:0] paddle_l,
  output logic [COORD_W-1:0] paddle_r,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [1:0]         game_state,
  output logic               point_pulse
);

  localparam int CNT_W  = (SERVE_DELAY < 2) ? 1 : $clog2(SERVE_DELAY + 1);
  localparam int DIFF_W = COORD_W + 1;

  localparam logic [COORD_W-1:0] X_CENTRE  = COORD_W'(SCREEN_W / 2);
  localparam logic [COORD_W-1:0] Y_CENTRE  = COORD_W'(SCREEN_H / 2);
  localparam logic [COORD_W-1:0] X_MAX     = COORD_W'(SCREEN_W - 1);
  localparam logic [COORD_W-1:0] X_HIT_R   = COORD_W'(SCREEN_W - 2);
  localparam logic [COORD_W-1:0] Y_MAX     = COORD_W'(SCREEN_H - 1);
  localparam logic [COORD_W-1:0] COORD_ONE = COORD_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_WIN = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(SERVE_DELAY);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic signed [DIFF_W-1:0] REACH = DIFF_W'(PADDLE_HALF);

  // Paddle covers the ball when |ball_y - paddle| <= PADDLE_HALF; one extra
  // signed bit keeps the difference from wrapping.
  function automatic logic in_reach(input logic [COORD_W-1:0] by,
                                    input logic [COORD_W-1:0] py);
    logic signed [DIFF_W-1:0] d;
    d = $signed({1'b0, by}) - $signed({1'b0, py});
    return (d <= REACH) && (d >= -REACH);
  endfunction

  game_state_e        state_q, state_d;
  logic [COORD_W-1:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic               vx_neg_q, vx_neg_d, vy_neg_q, vy_neg_d;
  logic [SCORE_W-1:0] score_l_q, score_r_q, score_l_inc, score_r_inc;
  logic [CNT_W-1:0]   serve_cnt_q;
  logic [7:0]         data_out_q, readout_d;
  logic               point_pulse_q;

  logic do_start, serve_tick, play_tick, paddle_en;
  logic score_l_evt, score_r_evt, win;

  // ---------------------------------------------------------------- FSM state
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ----------------------------------------------------------- FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_OVER: if (start) state_d = ST_SERVE;
      ST_SERVE:         if (tick && (serve_cnt_q <= CNT_ONE)) state_d = ST_PLAY;
      ST_PLAY:          if (score_l_evt || score_r_evt) state_d = win ? ST_OVER : ST_SERVE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------- FSM output decode
  // start wins over a coincident tick because only one strobe is decoded per state.
  always_comb begin
    do_start   = 1'b0;
    serve_tick = 1'b0;
    play_tick  = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: do_start   = start;
      ST_SERVE:         serve_tick = tick;
      ST_PLAY:          play_tick  = tick;
      default:          ;
    endcase
    paddle_en = serve_tick | play_tick;
  end

  // ------------------------------------------------------------------ paddles
  pong_paddle #(.COORD_W(COORD_W), .SCREEN_H(SCREEN_H), .PADDLE_HALF(PADDLE_HALF)) u_paddle_l (
    .clk(clk), .rst_n(rst_n), .en(paddle_en), .up(up_l), .dn(dn_l), .pos(paddle_l)
  );

  pong_paddle #(.COORD_W(COORD_W), .SCREEN_H(SCREEN_H), .PADDLE_HALF(PADDLE_HALF)) u_paddle_r (
    .clk(clk), .rst_n(rst_n), .en(paddle_en), .up(up_r), .dn(dn_r), .pos(paddle_r)
  );

  // ------------------------------------------------------------------ scoring
  // A ball sitting on an edge column at a play tick is a point; it does not move.
  assign score_r_evt = play_tick && (ball_x_q == '0);
  assign score_l_evt = play_tick && (ball_x_q == X_MAX);
  assign score_l_inc = score_l_q + SCORE_ONE;
  assign score_r_inc = score_r_q + SCORE_ONE;
  assign win = (score_l_evt && (score_l_inc == SCORE_WIN)) ||
               (score_r_evt && (score_r_inc == SCORE_WIN));

  // ------------------------------------------------------------- ball motion
  // Paddle compare uses the registered (pre-tick) paddle positions.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    vx_neg_d = vx_neg_q;
    vy_neg_d = vy_neg_q;
    if (do_start) begin
      ball_x_d = X_CENTRE;
      ball_y_d = Y_CENTRE;
    end else if (score_l_evt || score_r_evt) begin
      ball_x_d = X_CENTRE;
      ball_y_d = Y_CENTRE;
      vy_neg_d = 1'b0;
      vx_neg_d = score_r_evt;  // serve toward the player who conceded
    end else if (play_tick) begin
      if (ball_y_q == '0)        vy_neg_d = 1'b0;
      else if (ball_y_q == Y_MAX) vy_neg_d = 1'b1;
      if ((ball_x_q == COORD_ONE) && vx_neg_q && in_reach(ball_y_q, paddle_l))
        vx_neg_d = 1'b0;
      else if ((ball_x_q == X_HIT_R) && !vx_neg_q && in_reach(ball_y_q, paddle_r))
        vx_neg_d = 1'b1;
      ball_y_d = vy_neg_d ? (ball_y_q - COORD_ONE) : (ball_y_q + COORD_ONE);
      ball_x_d = vx_neg_d ? (ball_x_q - COORD_ONE) : (ball_x_q + COORD_ONE);
    end
  end

  // ------------------------------------------------------------------ readout
  always_comb begin
    readout_d = 8'd0;
    case (sel)
      SEL_BALL_X:   readout_d = 8'(ball_x_q);
      SEL_BALL_Y:   readout_d = 8'(ball_y_q);
      SEL_PADDLE_L: readout_d = 8'(paddle_l);
      SEL_PADDLE_R: readout_d = 8'(paddle_r);
      SEL_SCORE_L:  readout_d = 8'(score_l_q);
      SEL_SCORE_R:  readout_d = 8'(score_r_q);
      SEL_STATE:    readout_d = {6'd0, state_q};
      SEL_ZERO:     readout_d = 8'd0;
      default:      readout_d = 8'd0;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ball_x_q      <= X_CENTRE;
      ball_y_q      <= Y_CENTRE;
      vx_neg_q      <= 1'b0;
      vy_neg_q      <= 1'b0;
      score_l_q     <= '0;
      score_r_q     <= '0;
      serve_cnt_q   <= '0;
      data_out_q    <= 8'd0;
      point_pulse_q <= 1'b0;
    end else begin
      ball_x_q      <= ball_x_d;
      ball_y_q      <= ball_y_d;
      vx_neg_q      <= vx_neg_d;
      vy_neg_q      <= vy_neg_d;
      data_out_q    <= readout_d;
      point_pulse_q <= score_l_evt | score_r_evt;
      if (do_start) begin
        score_l_q   <= '0;
        score_r_q   <= '0;
        serve_cnt_q <= CNT_LOAD;
      end else begin
        if (score_l_evt) score_l_q <= score_l_inc;
        if (score_r_evt) score_r_q <= score_r_inc;
        if (score_l_evt || score_r_evt) serve_cnt_q <= CNT_LOAD;
        else if (serve_tick)            serve_cnt_q <= serve_cnt_q - CNT_ONE;
      end
    end
  end

  assign ball_x      = ball_x_q;
  assign ball_y      = ball_y_q;
  assign score_l     = score_l_q;
  assign score_r     = score_r_q;
  assign game_state  = state_q;
  assign data_out    = data_out_q;
  assign point_pulse = point_pulse_q;

endmodule

// File: tb/tb_pong_engine.sv
// Self-checking bench for pong_engine: a behavioural model predicts every
// output each clock (expected snapshots queued at drive time, compared after
// the edge), a table of phases pins hand-derived checkpoints, and short
// hand-written sequences cover scoring, winning and mid-game reset.
module tb_pong_engine;

  localparam int W   = 64;
  localparam int H   = 48;
  localparam int CW  = 8;
  localparam int PH  = 3;
  localparam int SW  = 4;
  localparam int WIN = 9;
  localparam int SD  = 8;

  logic          clk = 1'b0;
  logic          rst_n, tick, start, up_l, dn_l, up_r, dn_r;
  logic [2:0]    sel;
  logic [7:0]    data_out;
  logic [CW-1:0] ball_x, ball_y, paddle_l, paddle_r;
  logic [SW-1:0] score_l, score_r;
  logic [1:0]    game_state;
  logic          point_pulse;

  always #5 clk = ~clk;

  pong_engine #(
    .SCREEN_W(W), .SCREEN_H(H), .COORD_W(CW), .PADDLE_HALF(PH),
    .SCORE_W(SW), .WIN_SCORE(WIN), .SERVE_DELAY(SD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start),
    .up_l(up_l), .dn_l(dn_l), .up_r(up_r), .dn_r(dn_r), .sel(sel),
    .data_out(data_out), .ball_x(ball_x), .ball_y(ball_y),
    .paddle_l(paddle_l), .paddle_r(paddle_r),
    .score_l(score_l), .score_r(score_r),
    .game_state(game_state), .point_pulse(point_pulse)
  );

  typedef struct {
    int bx, by, pl, pr, sl, sr, st, pulse, dout;
  } snap_t;

  typedef struct {
    string name;
    bit    start, tick, ul, dl, ur, dr;
    int    n;
    int    st, pl, pr, bx, by;
  } phase_t;

  snap_t sb_q[$];

  // Model state; velocities held as +1/-1.
  int m_bx = W/2, m_by = H/2, m_vx = 1, m_vy = 1;
  int m_pl = H/2, m_pr = H/2, m_sl = 0, m_sr = 0;
  int m_cnt = 0, m_st = 0, m_pulse = 0, m_dout = 0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int pmove(input int p, input bit u, input bit d);
    if (u && !d) return (p > PH) ? p - 1 : p;
    if (d && !u) return (p < H - 1 - PH) ? p + 1 : p;
    return p;
  endfunction

  task automatic model_step(input bit rv, input bit st_in, input bit tk,
                            input bit ul, input bit dl, input bit ur, input bit dr,
                            input int s);
    int vals[8];
    int pl0, pr0, by0;
    vals = '{m_bx, m_by, m_pl, m_pr, m_sl, m_sr, m_st, 0};
    m_dout  = vals[s];
    m_pulse = 0;
    if (!rv) begin
      m_bx = W/2; m_by = H/2; m_vx = 1; m_vy = 1;
      m_pl = H/2; m_pr = H/2; m_sl = 0; m_sr = 0;
      m_cnt = 0; m_st = 0; m_dout = 0;
    end else if ((m_st == 0 || m_st == 3) && st_in) begin
      m_st = 1; m_sl = 0; m_sr = 0; m_bx = W/2; m_by = H/2; m_cnt = SD;
    end else if (m_st == 1 && tk) begin
      m_pl = pmove(m_pl, ul, dl);
      m_pr = pmove(m_pr, ur, dr);
      if (m_cnt == 1) m_st = 2;
      m_cnt = m_cnt - 1;
    end else if (m_st == 2 && tk) begin
      pl0 = m_pl; pr0 = m_pr; by0 = m_by;
      m_pl = pmove(m_pl, ul, dl);
      m_pr = pmove(m_pr, ur, dr);
      if (m_bx == 0 || m_bx == W - 1) begin
        if (m_bx == 0) begin m_sr = m_sr + 1; m_vx = -1; end
        else           begin m_sl = m_sl + 1; m_vx = 1;  end
        m_pulse = 1; m_bx = W/2; m_by = H/2; m_vy = 1; m_cnt = SD;
        m_st = (m_sr == WIN || m_sl == WIN) ? 3 : 1;
      end else begin
        if (by0 == 0)          m_vy = 1;
        else if (by0 == H - 1) m_vy = -1;
        m_by = by0 + m_vy;
        if (m_bx == 1 && m_vx == -1 && iabs(by0 - pl0) <= PH)         m_vx = 1;
        else if (m_bx == W - 2 && m_vx == 1 && iabs(by0 - pr0) <= PH) m_vx = -1;
        m_bx = m_bx + m_vx;
      end
    end
    sb_q.push_back('{m_bx, m_by, m_pl, m_pr, m_sl, m_sr, m_st, m_pulse, m_dout});
  endtask

  // Drive one clock of stimulus, predict, then compare after the edge.
  task automatic cycle(input bit rv, input bit st_in, input bit tk,
                       input bit ul, input bit dl, input bit ur, input bit dr,
                       input int s);
    snap_t e;
    rst_n = rv; start = st_in; tick = tk;
    up_l = ul; dn_l = dl; up_r = ur; dn_r = dr; sel = 3'(s);
    model_step(rv, st_in, tk, ul, dl, ur, dr, s);
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    check("ball_x",      int'(ball_x),      e.bx);
    check("ball_y",      int'(ball_y),      e.by);
    check("paddle_l",    int'(paddle_l),    e.pl);
    check("paddle_r",    int'(paddle_r),    e.pr);
    check("score_l",     int'(score_l),     e.sl);
    check("score_r",     int'(score_r),     e.sr);
    check("game_state",  int'(game_state),  e.st);
    check("point_pulse", int'(point_pulse), e.pulse);
    check("data_out",    int'(data_out),    e.dout);
  endtask

  phase_t ph[7];

  initial begin
    bit ur, dr, ul, dl, seen;

    ph[0] = '{"idle_hold",  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5,  0, 24, 24, 32, 24};
    ph[1] = '{"start_prio", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1,  1, 24, 24, 32, 24};
    ph[2] = '{"serve",      1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 7,  1, 17, 31, 32, 24};
    ph[3] = '{"serve_end",  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1,  2, 16, 32, 32, 24};
    ph[4] = '{"first_move", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1,  2, 15, 33, 33, 25};
    ph[5] = '{"paddle_sat", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 21, 2, 3,  44, 54, 46};
    ph[6] = '{"both_held",  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4,  2, 3,  44, 58, 44};

    // Reset state.
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    check("rst_ball_x",   int'(ball_x),     32);
    check("rst_ball_y",   int'(ball_y),     24);
    check("rst_paddle_l", int'(paddle_l),   24);
    check("rst_paddle_r", int'(paddle_r),   24);
    check("rst_scores",   int'(score_l) + int'(score_r), 0);
    check("rst_state",    int'(game_state), 0);
    check("rst_data_out", int'(data_out),   0);

    // Table-driven phases: idle hold, serve, paddle saturation, wall bounce.
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < ph[i].n; k++)
        cycle(1'b1, ph[i].start, ph[i].tick, ph[i].ul, ph[i].dl, ph[i].ur, ph[i].dr,
              int'($urandom_range(0, 7)));
      check({ph[i].name, "_state"},    int'(game_state), ph[i].st);
      check({ph[i].name, "_paddle_l"}, int'(paddle_l),   ph[i].pl);
      check({ph[i].name, "_paddle_r"}, int'(paddle_r),   ph[i].pr);
      check({ph[i].name, "_ball_x"},   int'(ball_x),     ph[i].bx);
      check({ph[i].name, "_ball_y"},   int'(ball_y),     ph[i].by);
    end

    // Right paddle tracks the ball, left is pinned at the top: right scores.
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      ur = m_pr > m_by;
      dr = m_pr < m_by;
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, ur, dr, int'($urandom_range(0, 7)));
      seen = point_pulse;
    end
    check("point_seen",      int'(seen),        1);
    check("point_score_r",   int'(score_r),     1);
    check("point_score_l",   int'(score_l),     0);
    check("point_state",     int'(game_state),  1);
    check("point_ball_x",    int'(ball_x),      32);
    check("point_ball_y",    int'(ball_y),      24);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5);
    check("pulse_one_clk",   int'(point_pulse), 0);
    check("pulse_dout",      int'(data_out),    1);
    for (int k = 0; k < 7; k++)
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, int'($urandom_range(0, 7)));
    check("reserve_play",    int'(game_state),  2);
    check("reserve_ball_x",  int'(ball_x),      32);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    check("serve_vx_left_x", int'(ball_x),      31);
    check("serve_vx_left_y", int'(ball_y),      25);

    // Keep the left paddle pinned until the right player wins.
    for (int k = 0; k < 2000 && game_state != 2'd3; k++)
      cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, int'($urandom_range(0, 7)));
    check("win_state",   int'(game_state), 3);
    check("win_score_r", int'(score_r),    9);
    check("win_score_l", int'(score_l),    0);
    for (int k = 0; k < 5; k++)
      cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, int'($urandom_range(0, 7)));
    check("over_state",    int'(game_state), 3);
    check("over_ball_x",   int'(ball_x),     32);
    check("over_ball_y",   int'(ball_y),     24);
    check("over_paddle_l", int'(paddle_l),   3);
    check("over_score_r",  int'(score_r),    9);

    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4);
    check("restart_state",   int'(game_state), 1);
    check("restart_score_l", int'(score_l),    0);
    check("restart_score_r", int'(score_r),    0);

    // Rally: both paddles track the ball, so every return is a hit.
    for (int k = 0; k < 300; k++) begin
      ul = m_pl > m_by; dl = m_pl < m_by;
      ur = m_pr > m_by; dr = m_pr < m_by;
      cycle(1'b1, 1'b0, 1'b1, ul, dl, ur, dr, int'($urandom_range(0, 7)));
    end
    check("rally_state",   int'(game_state), 2);
    check("rally_score_l", int'(score_l),    0);
    check("rally_score_r", int'(score_r),    0);

    // Reset mid-game wins over tick and start.
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2);
    check("mid_rst_ball_x",   int'(ball_x),      32);
    check("mid_rst_ball_y",   int'(ball_y),      24);
    check("mid_rst_paddle_l", int'(paddle_l),    24);
    check("mid_rst_paddle_r", int'(paddle_r),    24);
    check("mid_rst_state",    int'(game_state),  0);
    check("mid_rst_data_out", int'(data_out),    0);
    check("mid_rst_pulse",    int'(point_pulse), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
